ulpi_phy_model: RTL

- Cycle-level behavioural model of the PHY side of a ULPI link.
- Drives dir/nxt/data toward the link controller and answers register reads/writes and transmit commands.
- Emits RX CMD bytes when line/VBUS status changes.
- Sits in the simulation bench and debug loopback builds, connected to the link controller's ULPI port in place of the physical PHY and IO block.

---
 rtl/ulpi_phy_model.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ulpi_phy_model.sv
// ulpi_phy_model: cycle-level behavioural model of the PHY side of a ULPI link.
// Answers register reads/writes, sinks transmit commands and emits RX CMD
// bytes when the bench-driven line/VBUS/host-disconnect status changes.
//
// Ports:
//   ulpi_clk        single clock, rising edge
//   ulpi_rst        synchronous active-high reset
//   ulpi_dir        PHY owns the bus when 1
//   ulpi_nxt        PHY throttle/accept
//   ulpi_stp        link stop
//   ulpi_data_in    link-to-PHY bus (TX CMD / register data)
//   ulpi_data_out   PHY-to-link bus, meaningful only while ulpi_dir=1
//   line_state      bench-driven LineState
//   vbus_state      bench-driven VBUS encoding
//   host_disconnect reported in RX CMD bit 5
//   func_ctrl       Function Control register (0x04)
//   otg_ctrl        OTG Control register (0x0A)
//
// Build option: define ULPI_SET_CLR_EN to enable set (base+1) / clear (base+2)
// aliases for Function Control (0x04), Interface Control (0x07) and OTG
// Control (0x0A). Without it the alias addresses are plain storage cells.
module ulpi_phy_model #(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic       ulpi_clk,
  input  logic       ulpi_rst,
  output logic       ulpi_dir,
  output logic       ulpi_nxt,
  input  logic       ulpi_stp,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  input  logic [1:0] line_state,
  input  logic [1:0] vbus_state,
  input  logic       host_disconnect,
  output logic [7:0] func_ctrl,
  output logic [7:0] otg_ctrl
);

  typedef enum logic [3:0] {
    IDLE,
    WR_ACK,
    WR_DATA,
    WR_STP,
    RD_ACK,
    RD_TURN1,
    RD_DATA,
    RD_TURN2,
    RXC_TURN1,
    RXC_DATA,
    RXC_TURN2,
    TX_SINK
  } state_t;

  state_t     state;
  logic [5:0] addr;
  logic [7:0] wr_data;
  logic [8:0] last_rxcmd;

  // Writable register file; 0x00..0x03 are the read-only ID bytes and have
  // no storage.
  logic [7:0] regs     [4:NUM_REGS-1];
  logic [7:0] reg_next [4:NUM_REGS-1];

  logic [7:0] rxcmd;
  logic       rx_pending;
  logic [7:0] rd_data;
  logic       alias_hit;

  assign rxcmd      = {2'b00, host_disconnect, 1'b0, vbus_state, line_state};
  // Bit 8 of last_rxcmd is a post-reset sentinel forcing the first RX CMD.
  assign rx_pending = (rxcmd != last_rxcmd[7:0]) || last_rxcmd[8];

  assign func_ctrl = regs[4];
  assign otg_ctrl  = regs[10];

  // Register read mux for the latched address.
  always_comb begin
    rd_data = '0;
    if (addr < 6'd4) begin
      case (addr[1:0])
        2'd0:    rd_data = VENDOR_ID[7:0];
        2'd1:    rd_data = VENDOR_ID[15:8];
        2'd2:    rd_data = PRODUCT_ID[7:0];
        default: rd_data = PRODUCT_ID[15:8];
      endcase
    end else begin
      for (int unsigned i = 4; i < NUM_REGS; i++) begin
        if (addr == 6'(i)) rd_data = regs[i];
      end
`ifdef ULPI_SET_CLR_EN
      case (addr)
        6'h05, 6'h06: rd_data = regs[4];
        6'h08, 6'h09: rd_data = regs[7];
        6'h0B, 6'h0C: rd_data = regs[10];
        default: ;
      endcase
`endif
    end
  end

  // Register file contents after committing wr_data to addr.
  always_comb begin
    for (int unsigned i = 4; i < NUM_REGS; i++) begin
      reg_next[i] = regs[i];
    end
    alias_hit = 1'b0;
`ifdef ULPI_SET_CLR_EN
    alias_hit = 1'b1;
    case (addr)
      6'h05:   reg_next[4]  = regs[4]  |  wr_data;
      6'h06:   reg_next[4]  = regs[4]  & ~wr_data;
      6'h08:   reg_next[7]  = regs[7]  |  wr_data;
      6'h09:   reg_next[7]  = regs[7]  & ~wr_data;
      6'h0B:   reg_next[10] = regs[10] |  wr_data;
      6'h0C:   reg_next[10] = regs[10] & ~wr_data;
      default: alias_hit = 1'b0;
    endcase
`endif
    if (!alias_hit) begin
      for (int unsigned i = 4; i < NUM_REGS; i++) begin
        if (addr == 6'(i)) reg_next[i] = wr_data;
      end
    end
    // Function Control Reset bit self-clears, so it is never stored.
    reg_next[4][5] = 1'b0;
  end

  // Outputs are registered: each transition loads the outputs belonging to
  // the state being entered.
  always_ff @(posedge ulpi_clk) begin
    if (ulpi_rst) begin
      state         <= IDLE;
      ulpi_dir      <= 1'b0;
      ulpi_nxt      <= 1'b0;
      ulpi_data_out <= '0;
      addr          <= '0;
      wr_data       <= '0;
      last_rxcmd    <= 9'h100;
      for (int unsigned i = 4; i < NUM_REGS; i++) begin
        regs[i] <= (i == 4) ? 8'h41 : ((i == 10) ? 8'h06 : 8'h00);
      end
    end else begin
      ulpi_dir      <= 1'b0;
      ulpi_nxt      <= 1'b0;
      ulpi_data_out <= '0;
      case (state)
        IDLE: begin
          // A link command always wins over a pending RX CMD.
          case (ulpi_data_in[7:6])
            2'b10: begin
              addr     <= ulpi_data_in[5:0];
              state    <= WR_ACK;
              ulpi_nxt <= 1'b1;
            end
            2'b11: begin
              addr     <= ulpi_data_in[5:0];
              state    <= RD_ACK;
              ulpi_nxt <= 1'b1;
            end
            2'b01: begin
              state    <= TX_SINK;
              ulpi_nxt <= 1'b1;
            end
            default: begin
              if (rx_pending) begin
                state    <= RXC_TURN1;
                ulpi_dir <= 1'b1;
              end
            end
          endcase
        end
        WR_ACK: begin
          state    <= WR_DATA;
          ulpi_nxt <= 1'b1;
        end
        WR_DATA: begin
          wr_data <= ulpi_data_in;
          state   <= ulpi_stp ? IDLE : WR_STP;
        end
        WR_STP: begin
          if (ulpi_stp) begin
            for (int unsigned i = 4; i < NUM_REGS; i++) begin
              regs[i] <= reg_next[i];
            end
            state <= IDLE;
          end
        end
        RD_ACK: begin
          state    <= RD_TURN1;
          ulpi_dir <= 1'b1;
        end
        RD_TURN1: begin
          state         <= RD_DATA;
          ulpi_dir      <= 1'b1;
          ulpi_data_out <= rd_data;
        end
        RD_DATA:  state <= RD_TURN2;
        RD_TURN2: state <= IDLE;
        RXC_TURN1: begin
          state         <= RXC_DATA;
          ulpi_dir      <= 1'b1;
          ulpi_data_out <= rxcmd;
          last_rxcmd    <= {1'b0, rxcmd};
        end
        RXC_DATA:  state <= RXC_TURN2;
        RXC_TURN2: state <= IDLE;
        TX_SINK: begin
          if (ulpi_stp) state <= IDLE;
          else          ulpi_nxt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
